// File: rtl/wback_seq.sv
// rtl/wback_seq.sv - writeback sequencer: 2-entry bundle FIFO feeding scalar/vector register file writes
module wback_seq #(
  parameter int REGI_BITS = 4,
  parameter int VECT_BITS = 2,
  parameter int REGI_SIZE = 16,
  parameter int VECT_SIZE = 8,
  parameter int ELEM_SIZE = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic                           is_vect_i,
  input  logic                           is_swap_i,
  input  logic [REGI_BITS-1:0]           dst_a_i,
  input  logic [REGI_BITS-1:0]           dst_b_i,
  input  logic [REGI_SIZE-1:0]           ialu_res_i,
  input  logic [REGI_SIZE-1:0]           iswa_res_i,
  input  logic [ELEM_SIZE*VECT_SIZE-1:0] valu_res_i,
  input  logic [ELEM_SIZE*VECT_SIZE-1:0] vswa_res_i,
  output logic                           rf_we_o,
  output logic [REGI_BITS-1:0]           rf_addr_o,
  output logic [REGI_SIZE-1:0]           rf_data_o,
  output logic                           vrf_we_o,
  output logic [VECT_BITS-1:0]           vrf_addr_o,
  output logic [ELEM_SIZE*VECT_SIZE-1:0] vrf_data_o,
  output logic [15:0]                    retired_o
);

  localparam int VW = ELEM_SIZE * VECT_SIZE;

  typedef enum logic [1:0] {IDLE, WR_A, WR_B} state_t;

  state_t state;

  // FIFO storage, one slot per field
  logic                 f_vect [2];
  logic                 f_swap [2];
  logic [REGI_BITS-1:0] f_dst_a [2];
  logic [REGI_BITS-1:0] f_dst_b [2];
  logic [REGI_SIZE-1:0] f_ialu [2];
  logic [REGI_SIZE-1:0] f_iswa [2];
  logic [VW-1:0]        f_valu [2];
  logic [VW-1:0]        f_vswa [2];

  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic [1:0] count_next;
  logic       ready_en;
  logic       push;
  logic       pop;

  logic                 wr_vect;
  logic [REGI_BITS-1:0] wr_addr;
  logic [REGI_SIZE-1:0] wr_sdata;
  logic [VW-1:0]        wr_vdata;

  // ready_en keeps in_ready low until the first edge after reset release;
  // a full FIFO refuses pushes even when the head pops this cycle
  assign in_ready_o = ready_en && (count != 2'd2);
  assign push       = in_valid_i && in_ready_o;
  assign pop        = ((state == WR_A) && !f_swap[rd_ptr]) || (state == WR_B);
  assign count_next = count + {1'b0, push} - {1'b0, pop};

  // Select the write for the current phase from the head entry
  always_comb begin
    wr_vect  = f_vect[rd_ptr];
    wr_addr  = f_dst_a[rd_ptr];
    wr_sdata = f_ialu[rd_ptr];
    wr_vdata = f_valu[rd_ptr];
    if (state == WR_B) begin
      wr_addr  = f_dst_b[rd_ptr];
      wr_sdata = f_iswa[rd_ptr];
      wr_vdata = f_vswa[rd_ptr];
    end
  end

  // FIFO payload capture; contents are don't-care while the slot is empty
  always_ff @(posedge clk_i) begin
    if (push) begin
      f_vect[wr_ptr]  <= is_vect_i;
      f_swap[wr_ptr]  <= is_swap_i;
      f_dst_a[wr_ptr] <= dst_a_i;
      f_dst_b[wr_ptr] <= dst_b_i;
      f_ialu[wr_ptr]  <= ialu_res_i;
      f_iswa[wr_ptr]  <= iswa_res_i;
      f_valu[wr_ptr]  <= valu_res_i;
      f_vswa[wr_ptr]  <= vswa_res_i;
    end
  end

  // Sequencer FSM, FIFO pointers, retire counter and registered write ports
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      ready_en   <= 1'b0;
      retired_o  <= 16'd0;
      rf_we_o    <= 1'b0;
      rf_addr_o  <= '0;
      rf_data_o  <= '0;
      vrf_we_o   <= 1'b0;
      vrf_addr_o <= '0;
      vrf_data_o <= '0;
    end else begin
      ready_en   <= 1'b1;
      count      <= count_next;
      rf_we_o    <= 1'b0;
      rf_addr_o  <= '0;
      rf_data_o  <= '0;
      vrf_we_o   <= 1'b0;
      vrf_addr_o <= '0;
      vrf_data_o <= '0;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) begin
        rd_ptr    <= ~rd_ptr;
        retired_o <= retired_o + 16'd1;
      end
      if (state != IDLE) begin
        if (wr_vect) begin
          vrf_we_o   <= 1'b1;
          vrf_addr_o <= wr_addr[VECT_BITS-1:0];
          vrf_data_o <= wr_vdata;
        end else begin
          rf_we_o   <= 1'b1;
          rf_addr_o <= wr_addr;
          rf_data_o <= wr_sdata;
        end
      end
      case (state)
        IDLE: if (count != 2'd0) state <= WR_A;
        WR_A: begin
          if (f_swap[rd_ptr])           state <= WR_B;
          else if (count_next != 2'd0)  state <= WR_A;
          else                          state <= IDLE;
        end
        WR_B: state <= (count_next != 2'd0) ? WR_A : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wback_seq.sv
// tb/tb_wback_seq.sv - directed self-checking bench for wback_seq
module tb_wback_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        is_vect;
  logic        is_swap;
  logic [3:0]  dst_a;
  logic [3:0]  dst_b;
  logic [15:0] ialu_res;
  logic [15:0] iswa_res;
  logic [63:0] valu_res;
  logic [63:0] vswa_res;
  logic        rf_we;
  logic [3:0]  rf_addr;
  logic [15:0] rf_data;
  logic        vrf_we;
  logic [1:0]  vrf_addr;
  logic [63:0] vrf_data;
  logic [15:0] retired;

  int n_checks = 0;
  int n_errors = 0;
  int viol = 0;
  int cyc = 0;
  logic saw_not_ready;
  logic [68:0] wr_q [$];
  int wr_t [$];

  wback_seq dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .is_vect_i(is_vect), .is_swap_i(is_swap), .dst_a_i(dst_a), .dst_b_i(dst_b),
    .ialu_res_i(ialu_res), .iswa_res_i(iswa_res), .valu_res_i(valu_res), .vswa_res_i(vswa_res),
    .rf_we_o(rf_we), .rf_addr_o(rf_addr), .rf_data_o(rf_data),
    .vrf_we_o(vrf_we), .vrf_addr_o(vrf_addr), .vrf_data_o(vrf_data),
    .retired_o(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Write monitor: records every strobe and counts port-rule violations
  always @(negedge clk) begin
    if (rf_we && vrf_we) viol++;
    if (!rf_we && (rf_addr != 0 || rf_data != 0)) viol++;
    if (!vrf_we && (vrf_addr != 0 || vrf_data != 0)) viol++;
    if (rf_we) begin
      wr_q.push_back({1'b0, rf_addr, 48'd0, rf_data});
      wr_t.push_back(cyc);
    end
    if (vrf_we) begin
      wr_q.push_back({1'b1, 2'b00, vrf_addr, vrf_data});
      wr_t.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_bundle(input logic v, input logic s, input logic [3:0] a, input logic [3:0] b,
                            input logic [15:0] ia, input logic [15:0] is, input logic [63:0] va,
                            input logic [63:0] vs);
    is_vect = v; is_swap = s; dst_a = a; dst_b = b;
    ialu_res = ia; iswa_res = is; valu_res = va; vswa_res = vs;
  endtask

  // Present the current bundle and return #1 after the edge that accepts it
  task automatic send();
    int t;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin
      saw_not_ready = 1'b1;
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) check("send_timeout", {79'd0, in_ready}, 80'd1);
    else begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int c0;
    rst_n = 1'b0; in_valid = 1'b0; saw_not_ready = 1'b0;
    set_bundle(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {79'd0, in_ready}, 80'd0);
    check("rst_strobes", {78'd0, rf_we, vrf_we}, 80'd0);
    check("rst_retired", {64'd0, retired}, 80'd0);
    @(negedge clk) rst_n = 1'b1;
    #1 check("ready_before_edge", {79'd0, in_ready}, 80'd0);
    @(posedge clk); #1;
    check("ready_after_edge", {79'd0, in_ready}, 80'd1);

    // Scalar add latency
    wr_q.delete(); wr_t.delete();
    set_bundle(0, 0, 4'd3, 4'd0, 16'h1234, 16'h0, 64'h0, 64'h0);
    send();
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("add_k1_we", {79'd0, rf_we}, 80'd0);
    check("add_k1_ret", {64'd0, retired}, 80'd0);
    @(posedge clk); #1;
    check("add_k2_write", {59'd0, rf_we, rf_addr, rf_data}, {59'd0, 1'b1, 4'd3, 16'h1234});
    check("add_k2_vwe", {79'd0, vrf_we}, 80'd0);
    check("add_k2_ret", {64'd0, retired}, 80'd1);
    @(posedge clk); #1;
    check("add_k3_we", {79'd0, rf_we}, 80'd0);

    // Vector swap
    wr_q.delete(); wr_t.delete();
    set_bundle(1, 1, 4'd1, 4'd2, 16'h0, 16'h0, 64'h0102030405060708, 64'hA0A0A0A0A0A0A0A0);
    send();
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("vswap_count", 80'(wr_q.size()), 80'd2);
    if (wr_q.size() == 2) begin
      check("vswap_a", {11'd0, wr_q[0]}, {11'd0, 1'b1, 2'b00, 2'd1, 64'h0102030405060708});
      check("vswap_b", {11'd0, wr_q[1]}, {11'd0, 1'b1, 2'b00, 2'd2, 64'hA0A0A0A0A0A0A0A0});
      check("vswap_consec", 80'(wr_t[1] - wr_t[0]), 80'd1);
    end
    check("vswap_ret", {64'd0, retired}, 80'd2);

    // Same-destination swap
    wr_q.delete(); wr_t.delete();
    set_bundle(0, 1, 4'd5, 4'd5, 16'h1111, 16'h2222, 64'h0, 64'h0);
    send();
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("same_count", 80'(wr_q.size()), 80'd2);
    if (wr_q.size() == 2) begin
      check("same_a", {11'd0, wr_q[0]}, {11'd0, 1'b0, 4'd5, 48'd0, 16'h1111});
      check("same_b", {11'd0, wr_q[1]}, {11'd0, 1'b0, 4'd5, 48'd0, 16'h2222});
    end

    // Back-pressure: three swaps with valid held high
    wr_q.delete(); wr_t.delete();
    saw_not_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_bundle(0, 1, 4'(i), 4'(i + 8), 16'(16'h100 + i), 16'(16'h200 + i), 64'h0, 64'h0);
      send();
    end
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("bp_saw_not_ready", {79'd0, saw_not_ready}, 80'd1);
    check("bp_count", 80'(wr_q.size()), 80'd6);
    if (wr_q.size() == 6) begin
      for (int i = 0; i < 3; i++) begin
        check("bp_a", {11'd0, wr_q[2*i]},   {11'd0, 1'b0, 4'(i),     48'd0, 16'(16'h100 + i)});
        check("bp_b", {11'd0, wr_q[2*i+1]}, {11'd0, 1'b0, 4'(i + 8), 48'd0, 16'(16'h200 + i)});
      end
    end
    check("bp_ret", {64'd0, retired}, 80'd6);

    // Reset between write A and write B
    wr_q.delete(); wr_t.delete();
    set_bundle(0, 1, 4'd7, 4'd9, 16'h7777, 16'h9999, 64'h0, 64'h0);
    send();
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_write_a", {59'd0, rf_we, rf_addr, rf_data}, {59'd0, 1'b1, 4'd7, 16'h7777});
    #1 rst_n = 1'b0;
    #1;
    check("mid_outputs", {5'd0, rf_we, rf_addr, rf_data, vrf_we, vrf_addr, vrf_data}, 80'd0);
    check("mid_retired", {64'd0, retired}, 80'd0);
    check("mid_ready", {79'd0, in_ready}, 80'd0);
    repeat (4) @(posedge clk);
    #1 check("mid_no_b", 80'(wr_q.size()), 80'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Throughput and retire-counter wrap
    wr_q.delete(); wr_t.delete();
    set_bundle(0, 0, 4'd1, 4'd0, 16'hBEEF, 16'h0, 64'h0, 64'h0);
    c0 = cyc;
    for (int i = 0; i < 65535; i++) send();
    in_valid = 1'b0;
    check("throughput", {79'd0, (cyc - c0) <= 65537}, 80'd1);
    repeat (4) @(posedge clk);
    #1 check("ret_ffff", {64'd0, retired}, 80'hFFFF);
    send();
    send();
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("ret_wrap", {64'd0, retired}, 80'd1);
    wr_q.delete(); wr_t.delete();

    check("port_rules", 80'(viol), 80'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
